// File: rtl/eexp_pkg.sv
// Shared types, state encoding and coefficient helper for the sequential e^x block.
package eexp_pkg;

   localparam int unsigned DEF_TOTAL_BITS      = 32;
   localparam int unsigned DEF_FRACTIONAL_BITS = 16;

   // Default-width datapath types; instantiating modules declare their own at their own widths.
   typedef logic signed [DEF_TOTAL_BITS-1:0]   value_type;
   typedef logic signed [2*DEF_TOTAL_BITS-1:0] mul_type;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   // trunc(2^f / k!), evaluated at elaboration to fill the coefficient ROM.
   function automatic longint unsigned inv_factorial(input int unsigned k, input int unsigned f);
      longint unsigned fact;
      longint unsigned one;
      fact = 1;
      one  = 1;
      for (int unsigned i = 2; i <= k; i++) begin
         fact = fact * 64'(i);
      end
      return (one << f) / fact;
   endfunction

endpackage

// File: rtl/eexp_seq_if.sv
// Valid/ready operand and result channel of the sequential e^x block.
interface eexp_seq_if #(
   parameter int unsigned TOTAL_BITS = 32
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [TOTAL_BITS-1:0] x;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [TOTAL_BITS-1:0] out;
   logic                         overflow;

   modport master (
      output in_valid, x, out_ready,
      input  in_ready, out_valid, out, overflow
   );

   modport slave (
      input  in_valid, x, out_ready,
      output in_ready, out_valid, out, overflow
   );
endinterface

// File: rtl/fxp_mul_add_sat.sv
// Combinational fixed-point step: (acc*x)>>>F + c, saturated to the word range.
module fxp_mul_add_sat #(
   parameter int unsigned TOTAL_BITS      = 32,
   parameter int unsigned FRACTIONAL_BITS = 16
) (
   input  logic signed [TOTAL_BITS-1:0] acc,
   input  logic signed [TOTAL_BITS-1:0] x,
   input  logic signed [TOTAL_BITS-1:0] c,
   output logic signed [TOTAL_BITS-1:0] sum,
   output logic                         ovf
);
   import eexp_pkg::*;

   typedef logic signed [TOTAL_BITS-1:0]   word_t;
   typedef logic signed [2*TOTAL_BITS-1:0] wide_t;

   localparam word_t MAX_V = {1'b0, {(TOTAL_BITS-1){1'b1}}};
   localparam word_t MIN_V = {1'b1, {(TOTAL_BITS-1){1'b0}}};
   localparam wide_t MAX_W = wide_t'(MAX_V);
   localparam wide_t MIN_W = wide_t'(MIN_V);

   wide_t prod;
   wide_t scaled;
   wide_t total;

   // Double-width multiply, arithmetic rescale (floor), add coefficient, clamp.
   always_comb begin
      prod   = wide_t'(acc) * wide_t'(x);
      scaled = prod >>> FRACTIONAL_BITS;
      total  = scaled + wide_t'(c);
      sum    = total[TOTAL_BITS-1:0];
      ovf    = 1'b0;
      if (total > MAX_W) begin
         sum = MAX_V;
         ovf = 1'b1;
      end else if (total < MIN_W) begin
         sum = MIN_V;
         ovf = 1'b1;
      end
   end

endmodule

// File: rtl/eexp_seq.sv
// Sequential e^x: Horner evaluation of a TERMS-term Taylor series, one multiply-add per clock.
module eexp_seq
   import eexp_pkg::*;
#(
   parameter int unsigned TOTAL_BITS      = 32,
   parameter int unsigned FRACTIONAL_BITS = 16,
   parameter int unsigned TERMS           = 5
) (
   input logic       clk,
   input logic       reset_n,
   eexp_seq_if.slave bus
);

   localparam int unsigned N        = TERMS - 1;
   localparam int unsigned IDX_BITS = $clog2(TERMS);
   localparam int unsigned ROM_SIZE = 1 << IDX_BITS;

   typedef logic signed [TOTAL_BITS-1:0] word_t;
   typedef logic [IDX_BITS-1:0]          kidx_t;

   // ROM padded to a power of two so the index is exactly IDX_BITS wide.
   word_t coef [ROM_SIZE];

   for (genvar g = 0; g < ROM_SIZE; g++) begin : g_coef
      if (g < TERMS) begin : g_used
         assign coef[g] = word_t'(inv_factorial(g, FRACTIONAL_BITS));
      end else begin : g_pad
         assign coef[g] = '0;
      end
   end

   state_t state;
   state_t state_next;
   word_t  acc;
   word_t  x_reg;
   kidx_t  k;
   logic   ovf;
   word_t  step_sum;
   logic   step_ovf;

   fxp_mul_add_sat #(
      .TOTAL_BITS      (TOTAL_BITS),
      .FRACTIONAL_BITS (FRACTIONAL_BITS)
   ) u_step (
      .acc (acc),
      .x   (x_reg),
      .c   (coef[k]),
      .sum (step_sum),
      .ovf (step_ovf)
   );

   // State register; reset abandons any calculation in progress.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and handshake outputs; negative results clamp to zero and flag overflow.
   always_comb begin
      state_next    = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out       = '0;
      bus.overflow  = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_next = CALC;
            end
         end
         CALC: begin
            if (k == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            bus.out       = acc[TOTAL_BITS-1] ? '0 : acc;
            bus.overflow  = ovf | acc[TOTAL_BITS-1];
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture at accept, then one Horner step per CALC cycle with sticky saturation.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc   <= '0;
         x_reg <= '0;
         k     <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  x_reg <= bus.x;
                  acc   <= coef[N];
                  k     <= kidx_t'(N - 1);
                  ovf   <= 1'b0;
               end
            end
            CALC: begin
               acc <= step_sum;
               ovf <= ovf | step_ovf;
               if (k != '0) begin
                  k <= k - kidx_t'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
